// File: rtl/datapath_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : datapath_seq_pkg
// Purpose  : Shared opcode constants, FSM state encoding and instruction
//            field positions for the datapath sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package datapath_seq_pkg;

    // Opcodes 0x0..OPC_ALU_MAX go straight to the function unit as op_sel
    localparam logic [3:0] OPC_ALU_MAX = 4'h9;
    localparam logic [3:0] OPC_LDI     = 4'hA;
    localparam logic [3:0] OPC_IN      = 4'hB;
    localparam logic [3:0] OPC_BZ      = 4'hC;
    localparam logic [3:0] OPC_JMP     = 4'hD;
    localparam logic [3:0] OPC_NOP     = 4'hE;
    localparam logic [3:0] OPC_HALT    = 4'hF;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_IOWAIT = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    // Instruction word field positions: opcode | d | a | b
    localparam int IR_OPC_HI = 15;
    localparam int IR_OPC_LO = 12;
    localparam int IR_D_HI   = 11;
    localparam int IR_D_LO   = 8;
    localparam int IR_A_HI   = 7;
    localparam int IR_A_LO   = 4;
    localparam int IR_B_HI   = 3;
    localparam int IR_B_LO   = 0;
    localparam int IR_IMM_HI = 7;
    localparam int IR_IMM_LO = 0;

    function automatic logic [3:0] ir_opcode(input logic [15:0] ir);
        return ir[IR_OPC_HI:IR_OPC_LO];
    endfunction

endpackage : datapath_seq_pkg
`default_nettype wire

// File: rtl/datapath_seq_decode.sv
`default_nettype none
// ============================================================================
// Module   : datapath_seq_decode
// Purpose  : Combinational decoder from sequencer state + instruction
//            register to datapath select lines and bus request strobes.
// Ports    : state_i, ir_i, io_ack_i in; select lines, load_en, const mux,
//            imem/io requests and busy/halted status out.
// Revision : 1.0 - initial release
// ============================================================================
module datapath_seq_decode
    import datapath_seq_pkg::*;
#(
    parameter logic [3:0] PASSB_OP = 4'd1
) (
    input  state_e      state_i,
    input  logic [15:0] ir_i,
    input  logic        io_ack_i,
    output logic        imem_req_o,
    output logic        io_req_o,
    output logic [3:0]  a_sel_o,
    output logic [3:0]  b_sel_o,
    output logic [3:0]  dest_sel_o,
    output logic        load_en_o,
    output logic [3:0]  op_sel_o,
    output logic        data_sel_o,
    output logic        const_sel_o,
    output logic [15:0] const_out_o,
    output logic        busy_o,
    output logic        halted_o
);

    logic [3:0] w_opc;
    assign w_opc = ir_opcode(ir_i);

    always_comb begin
        imem_req_o  = 1'b0;
        io_req_o    = 1'b0;
        a_sel_o     = 4'h0;
        b_sel_o     = 4'h0;
        dest_sel_o  = 4'h0;
        load_en_o   = 1'b0;
        op_sel_o    = 4'h0;
        data_sel_o  = 1'b0;
        const_sel_o = 1'b0;
        const_out_o = 16'h0000;
        busy_o      = 1'b0;
        halted_o    = 1'b0;
        case (state_i)
            ST_FETCH: begin
                imem_req_o = 1'b1;
                busy_o     = 1'b1;
            end
            ST_EXEC: begin
                busy_o = 1'b1;
                if (w_opc <= OPC_ALU_MAX) begin
                    a_sel_o    = ir_i[IR_A_HI:IR_A_LO];
                    b_sel_o    = ir_i[IR_B_HI:IR_B_LO];
                    dest_sel_o = ir_i[IR_D_HI:IR_D_LO];
                    op_sel_o   = w_opc;
                    load_en_o  = 1'b1;
                end else if (w_opc == OPC_LDI) begin
                    // Immediate enters on the b side and is passed through
                    op_sel_o    = PASSB_OP;
                    const_sel_o = 1'b1;
                    const_out_o = {8'h00, ir_i[IR_IMM_HI:IR_IMM_LO]};
                    dest_sel_o  = ir_i[IR_D_HI:IR_D_LO];
                    load_en_o   = 1'b1;
                end
            end
            ST_IOWAIT: begin
                busy_o     = 1'b1;
                io_req_o   = 1'b1;
                data_sel_o = 1'b1;
                dest_sel_o = ir_i[IR_D_HI:IR_D_LO];
                load_en_o  = io_ack_i;
            end
            ST_HALT: begin
                halted_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule : datapath_seq_decode
`default_nettype wire

// File: rtl/datapath_seq.sv
`default_nettype none
// ============================================================================
// Module   : datapath_seq
// Purpose  : Fetch/decode/execute sequencer for the 16-register datapath.
//            Fetches instruction words over imem req/ack, drives the
//            register-file/function-unit select lines, and keeps the
//            registered zero flag used by BZ.
// Ports    : clk, rst_n, start; imem_req/addr/ack/data fetch port;
//            io_req/io_ack external data port; z flag in; a/b/dest/op
//            selects, load_en, data_sel, const_sel, const_out, busy, halted.
// Revision : 1.0 - initial release
// ============================================================================
module datapath_seq
    import datapath_seq_pkg::*;
#(
    parameter int         PC_W     = 8,
    parameter logic [3:0] PASSB_OP = 4'd1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic            io_req,
    input  logic            io_ack,
    input  logic            z,
    output logic [3:0]      a_sel,
    output logic [3:0]      b_sel,
    output logic [3:0]      dest_sel,
    output logic            load_en,
    output logic [3:0]      op_sel,
    output logic            data_sel,
    output logic            const_sel,
    output logic [15:0]     const_out,
    output logic            busy,
    output logic            halted
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            zflag_q, zflag_d;

    logic [3:0]      w_opc;
    logic [PC_W+7:0] w_off_ext;

    assign w_opc     = ir_opcode(ir_q);
    // Branch offset is a signed byte; widen then keep the low PC_W bits so
    // the add wraps modulo 2^PC_W for any PC_W.
    assign w_off_ext = {{PC_W{ir_q[IR_IMM_HI]}}, ir_q[IR_IMM_HI:IR_IMM_LO]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            zflag_q <= zflag_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        zflag_d = zflag_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                if (w_opc <= OPC_ALU_MAX) begin
                    zflag_d = z;
                end else begin
                    case (w_opc)
                        OPC_IN:   state_d = ST_IOWAIT;
                        OPC_BZ:   if (zflag_q) pc_d = pc_q + w_off_ext[PC_W-1:0];
                        OPC_JMP:  pc_d = ir_q[PC_W-1:0];
                        OPC_HALT: state_d = ST_HALT;
                        default:  ;
                    endcase
                end
            end
            ST_IOWAIT: begin
                if (io_ack) state_d = ST_FETCH;
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_addr = pc_q;

    // Output logic
    datapath_seq_decode #(
        .PASSB_OP (PASSB_OP)
    ) u_seq_decode (
        .state_i     (state_q),
        .ir_i        (ir_q),
        .io_ack_i    (io_ack),
        .imem_req_o  (imem_req),
        .io_req_o    (io_req),
        .a_sel_o     (a_sel),
        .b_sel_o     (b_sel),
        .dest_sel_o  (dest_sel),
        .load_en_o   (load_en),
        .op_sel_o    (op_sel),
        .data_sel_o  (data_sel),
        .const_sel_o (const_sel),
        .const_out_o (const_out),
        .busy_o      (busy),
        .halted_o    (halted)
    );

endmodule : datapath_seq
`default_nettype wire

// File: tb/tb_datapath_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_seq
// Purpose  : Self-checking bench for datapath_seq: single-instruction vector
//            table, directed multi-cycle sequences, and a randomized program
//            run against an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_seq;

    localparam int         PC_W  = 8;
    localparam logic [3:0] PASSB = 4'd1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack = 1'b0;
    logic [15:0]     imem_data = 16'h0;
    logic            io_req;
    logic            io_ack = 1'b0;
    logic            z = 1'b0;
    logic [3:0]      a_sel, b_sel, dest_sel, op_sel;
    logic            load_en, data_sel, const_sel, busy, halted;
    logic [15:0]     const_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural pc and zero flag
    logic [7:0] mpc;
    logic       mz;
    logic [15:0] imem [256];

    always #5 clk = ~clk;

    datapath_seq #(.PC_W(PC_W), .PASSB_OP(PASSB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .io_req(io_req), .io_ack(io_ack), .z(z),
        .a_sel(a_sel), .b_sel(b_sel), .dest_sel(dest_sel), .load_en(load_en),
        .op_sel(op_sel), .data_sel(data_sel), .const_sel(const_sel),
        .const_out(const_out), .busy(busy), .halted(halted)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; io_ack = 1'b0; z = 1'b0;
        imem_data = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        mpc = 8'h00;
        mz  = 1'b0;
    endtask

    // Execute one instruction through fetch, EXEC and (for IN) IOWAIT,
    // checking every cycle against the model, then update the model.
    task automatic do_instr(input logic [15:0] instr, input int fw,
                            input logic zin, input int iow);
        logic [3:0]  opc;
        logic        e_load, e_cs;
        logic [3:0]  e_dest, e_a, e_b, e_op;
        logic [15:0] e_co;
        opc = instr[15:12];
        for (int c = 0; c <= fw; c++) begin
            imem_ack  = (c == fw);
            imem_data = (c == fw) ? instr : 16'($urandom);
            #1;
            chk("fetch", {imem_req, busy, load_en, io_req, halted, imem_addr},
                {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mpc});
            tick();
        end
        imem_ack = 1'b0;
        mpc = mpc + 8'd1;

        // Expected EXEC outputs from the opcode table
        e_load = (opc <= 4'd9) || (opc == 4'hA);
        e_dest = e_load ? instr[11:8] : 4'h0;
        e_a    = (opc <= 4'd9) ? instr[7:4] : 4'h0;
        e_b    = (opc <= 4'd9) ? instr[3:0] : 4'h0;
        e_op   = (opc <= 4'd9) ? opc : ((opc == 4'hA) ? PASSB : 4'h0);
        e_cs   = (opc == 4'hA);
        e_co   = (opc == 4'hA) ? {8'h00, instr[7:0]} : 16'h0;
        z = zin;
        #1;
        chk("exec", {load_en, dest_sel, a_sel, b_sel, op_sel, const_sel, const_out,
                     data_sel, io_req, imem_req, busy, halted},
            {e_load, e_dest, e_a, e_b, e_op, e_cs, e_co,
             1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tick();
        z = 1'b0;

        if (opc <= 4'd9) mz = zin;
        if (opc == 4'hC && mz) mpc = 8'((int'(mpc) + int'($signed(instr[7:0]))) & 255);
        if (opc == 4'hD) mpc = instr[7:0];

        if (opc == 4'hB) begin
            for (int c = 0; c <= iow; c++) begin
                io_ack = (c == iow);
                #1;
                chk("iowait", {io_req, data_sel, load_en, dest_sel, imem_req, busy},
                    {1'b1, 1'b1, (c == iow), instr[11:8], 1'b0, 1'b1});
                tick();
            end
            io_ack = 1'b0;
        end
        if (opc == 4'hF) begin
            chk("halt", {halted, busy, imem_req, io_req, load_en}, 5'b10000);
        end
    endtask

    typedef struct {
        logic [15:0] instr;
        logic        load;
        logic [3:0]  dest;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  op;
        logic        cs;
        logic [15:0] co;
        logic [7:0]  next_pc;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{16'h3210, 1'b1, 4'h2, 4'h1, 4'h0, 4'h3, 1'b0, 16'h0000, 8'h01};
        vecs[1] = '{16'h9FED, 1'b1, 4'hF, 4'hE, 4'hD, 4'h9, 1'b0, 16'h0000, 8'h01};
        vecs[2] = '{16'hA105, 1'b1, 4'h1, 4'h0, 4'h0, 4'h1, 1'b1, 16'h0005, 8'h01};
        vecs[3] = '{16'hAFFF, 1'b1, 4'hF, 4'h0, 4'h0, 4'h1, 1'b1, 16'h00FF, 8'h01};
        vecs[4] = '{16'hD0FF, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 8'hFF};
        vecs[5] = '{16'hE123, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 8'h01};
        vecs[6] = '{16'hC0FE, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 8'h01};
        vecs[7] = '{16'h0000, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 8'h01};

        // Reset state
        do_reset();
        chk("reset_outs", {imem_req, imem_addr, io_req, a_sel, b_sel, dest_sel, load_en,
                           op_sel, data_sel, const_sel, const_out, busy, halted}, '0);

        // Single-instruction vector table from reset
        for (int i = 0; i < 8; i++) begin
            do_reset();
            do_start();
            imem_ack = 1'b1; imem_data = vecs[i].instr;
            #1;
            chk("tbl_fetch", {imem_req, imem_addr, busy}, {1'b1, 8'h00, 1'b1});
            tick();
            imem_ack = 1'b0;
            #1;
            chk("tbl_exec", {load_en, dest_sel, a_sel, b_sel, op_sel, const_sel, const_out},
                {vecs[i].load, vecs[i].dest, vecs[i].a, vecs[i].b, vecs[i].op,
                 vecs[i].cs, vecs[i].co});
            tick();
            chk("tbl_next_pc", {imem_req, imem_addr}, {1'b1, vecs[i].next_pc});
        end

        // LDI / ALU / HALT program, then start must not leave HALT
        do_reset();
        do_start();
        do_instr(16'hA105, 0, 1'b0, 0);
        do_instr(16'h3210, 0, 1'b0, 0);
        do_instr(16'hF000, 0, 1'b0, 0);
        do_instr_start_in_halt();

        // BZ taken (z=1 on prior ALU) and not taken
        for (int t = 0; t < 2; t++) begin
            do_reset();
            do_start();
            do_instr(16'hE000, 0, 1'b0, 0);
            do_instr(16'hE000, 1, 1'b0, 0);
            do_instr(16'hE000, 0, 1'b0, 0);
            do_instr(16'h2345, 0, (t == 0), 0);
            do_instr(16'hC0FE, 0, 1'b0, 0);
            #1;
            chk("bz_target", imem_addr, (t == 0) ? 8'h03 : 8'h05);
        end

        // IN r7 with ack on the 4th IOWAIT cycle
        do_reset();
        do_start();
        do_instr(16'hB700, 2, 1'b0, 3);
        chk("in_done", {imem_req, imem_addr}, {1'b1, 8'h01});

        // JMP to the top of the address space, then wrap
        do_reset();
        do_start();
        do_instr(16'hD0FF, 0, 1'b0, 0);
        do_instr(16'hE000, 0, 1'b0, 0);
        chk("pc_wrap", imem_addr, 8'h00);

        // Reset while fetch request is outstanding
        do_reset();
        do_start();
        do_instr(16'hE000, 0, 1'b0, 0);
        do_instr(16'hE000, 0, 1'b0, 0);
        #2;
        chk("pre_rst_req", {imem_req, imem_addr}, {1'b1, 8'h02});
        rst_n = 1'b0;
        #1;
        chk("rst_drops_req", imem_req, 1'b0);
        imem_ack = 1'b1; imem_data = 16'hA1FF;
        tick();
        rst_n = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("rst_idle", {imem_req, busy, imem_addr, load_en, halted}, '0);

        // Randomized program against the model (no HALT so the run is bounded)
        for (int i = 0; i < 256; i++) begin
            logic [3:0] o;
            o = 4'($urandom_range(0, 14));
            imem[i] = {o, 12'($urandom)};
        end
        do_reset();
        do_start();
        for (int k = 0; k < 400; k++) begin
            do_instr(imem[mpc], int'($urandom_range(0, 2)), 1'($urandom),
                     int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic do_instr_start_in_halt();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("halt_sticky", {halted, busy, imem_req}, 3'b100);
    endtask

endmodule : tb_datapath_seq
`default_nettype wire

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Fetch/decode/execute sequencer for the 16-register datapath: register file, function unit, data-in mux and constant mux.
- Fetches 16-bit instruction words over a req/ack port, then drives the datapath select lines and register load enable.
- Registers the function-unit zero flag for conditional branches.
- Sits between the instruction memory/IO bus and the datapath at the top level.

Parameters:
- PC_W, 8, program counter and instruction address width.
- PASSB_OP, 4'd1, op_sel code that makes the function unit pass operand b unchanged (used by LDI).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: leave IDLE and begin fetching at pc=0.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address (equals pc).
- imem_ack  in  1  instruction word valid this cycle.
- imem_data  in  16  instruction word.
- io_req  out  1  request for an external word on data_in.
- io_ack  in  1  data_in valid this cycle.
- z  in  1  zero flag from the function unit (combinational).
- a_sel  out  4  register-file read port A.
- b_sel  out  4  register-file read port B.
- dest_sel  out  4  register-file write address.
- load_en  out  1  register-file write strobe; one cycle per writing instruction.
- op_sel  out  4  function-unit operation.
- data_sel  out  1  0 = function-unit result, 1 = data_in.
- const_sel  out  1  0 = b_end, 1 = const_out.
- const_out  out  16  immediate value fed to the constant mux.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.

Behaviour:
- Reset, asynchronous: state=IDLE, pc=0, ir=0, z_flag=0. All outputs are 0.
- Instruction format: ir[15:12] opcode, ir[11:8] d, ir[7:4] a, ir[3:0] b.
- Opcodes:
  - 0x0–0x9 ALU: op_sel=opcode.
  - 0xA LDI: d <- {8'h00, ir[7:0]}.
  - 0xB IN: d <- data_in.
  - 0xC BZ: branch if zero.
  - 0xD JMP: pc <- ir[PC_W-1:0].
  - 0xE NOP.
  - 0xF HALT.
- States: IDLE, FETCH, EXEC, IOWAIT, HALT.
- IDLE: waits for start. On start: pc=0, go to FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc, held stable until imem_ack.
  - On ack: ir <- imem_data, pc <- pc+1 (wraps modulo 2^PC_W), go to EXEC.
  - Zero ack-wait cycles are allowed, so minimum fetch is 1 cycle.
- EXEC lasts one cycle. Select lines are decoded combinationally from ir.
  - ALU: a_sel=a, b_sel=b, dest_sel=d, const_sel=0, data_sel=0, load_en=1. z_flag <- z at the end of the cycle.
  - LDI: op_sel=PASSB_OP, const_sel=1, const_out={8'h00, ir[7:0]}, dest_sel=d, load_en=1. z_flag unchanged.
  - IN: go to IOWAIT, load_en=0.
  - BZ: if z_flag, pc <- pc + sign-extended ir[7:0], truncated to PC_W. Otherwise pc unchanged.
  - JMP: pc <- ir[PC_W-1:0].
  - NOP: no effect.
  - HALT: go to HALT.
  - Every opcode except IN and HALT returns to FETCH.
- IOWAIT:
  - io_req=1, data_sel=1, dest_sel=d.
  - load_en=1 only in the cycle io_ack=1, then go to FETCH.
  - A same-cycle ack completes in one IOWAIT cycle.
- HALT: sticky. Only rst_n exits it; start is ignored.
- start outside IDLE is ignored.
- load_en is never high outside EXEC (ALU/LDI) or the acked IOWAIT cycle.
- Reset mid-fetch or mid-IO drops req immediately. An in-flight ack arriving after reset is ignored.
- Latency per instruction: fetch cycles + 1. IN additionally takes its IOWAIT cycles.

Decomposition:
- Shared package holds:
  - opcode constants OPC_ALU_MAX=4'h9, OPC_LDI, OPC_IN, OPC_BZ, OPC_JMP, OPC_NOP, OPC_HALT;
  - state encodings;
  - instruction field bit ranges.
- One natural sub-module: seq_decode, a combinational ir + state -> select-line decoder. The FSM, pc and z_flag stay in datapath_seq.

Test Plan:
- Reset with all inputs 0, then start; ack each fetch at once -> imem_req=1, imem_addr=0; on ack the next EXEC is reached one cycle later; busy=1.
- Program LDI r1,0x05 → ALU op3 r2=r1,r0 → HALT, acked instantly -> EXEC cycles show load_en=1, dest_sel=1, const_sel=1, const_out=0x0005, op_sel=PASSB_OP; then dest_sel=2, op_sel=3, a_sel=1, b_sel=0; then halted=1 and a later start has no effect.
- BZ offset 0xFE at addr 4 with z=1 during the prior ALU EXEC -> next imem_addr=3. Repeat with z=0 -> next imem_addr=5.
- IN r7 with io_ack delayed 3 cycles -> io_req high for 4 cycles; load_en=1, data_sel=1, dest_sel=7 only in the ack cycle.
- JMP 0xFF then NOP with PC_W=8 -> fetch at 0xFF, then pc wraps to 0x00.
- Assert rst_n low while in FETCH with imem_req=1 -> imem_req falls the same cycle (async); after release, state=IDLE and pc=0.
